// File: rtl/z80_glue_pkg.sv
// Shared definitions for the Z80 IM2 interrupt controller:
// register addresses, acknowledge FSM states, priority encoder.
package z80_glue_pkg;

  localparam logic [2:0] INTC_MASK  = 3'd0;
  localparam logic [2:0] INTC_MODE  = 3'd1;
  localparam logic [2:0] INTC_PEND  = 3'd2;
  localparam logic [2:0] INTC_VBASE = 3'd3;
  localparam logic [2:0] INTC_INSVC = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_SKIP = 2'd2
  } intc_state_t;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    msb_index = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) msb_index = 3'(i);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-channel IRQ synchroniser with rising-edge detect.
// Ports: clk, rst (async high), irq (async in), s (synced), rise (1-clk pulse).
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      s_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_q;

endmodule

// File: rtl/z80_im2_intc.sv
// Z80 Mode-2 interrupt controller: mask/mode/pending/in-service regs,
// nested priority with EOI, vector base, IEI/IEO daisy chain.
// Ports: CLK, RESET, IRQ, CPU bus (addr/din/cs/rd/wr/m1/iorq),
// IEI/IEO chain, DOUT + nDOUTxEN bus drive, nINT request.
module z80_im2_intc
  import z80_glue_pkg::*;
#(
  parameter int         NUM_IRQ     = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_MASK  = 8'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [2:0]         CPU_ADDR,
  input  logic [7:0]         CPU_DIN,
  input  logic               nCSxINTC,
  input  logic               nCPUxRD,
  input  logic               nCPUxWR,
  input  logic               nCPUxM1,
  input  logic               nCPUxIORQ,
  input  logic               IEI,
  output logic [7:0]         DOUT,
  output logic               nDOUTxEN,
  output logic               nINT,
  output logic               IEO
);

  localparam logic [7:0] VALID =
    8'((16'd1 << NUM_IRQ) - 16'd1);

  logic [7:0]  s_v, rise_v;
  logic [7:0]  mask_q, mode_q;
  logic [7:0]  pend_q, insvc_q;
  logic [3:0]  vbase_q;
  logic [2:0]  ackch_q;
  logic [7:0]  vec_q;
  logic        wr_q, nint_q;
  intc_state_t state_q;

  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < NUM_IRQ) begin : g_on
      irq_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .irq (IRQ[g]),
        .s   (s_v[g]),
        .rise(rise_v[g])
      );
    end else begin : g_off
      assign s_v[g]    = 1'b0;
      assign rise_v[g] = 1'b0;
    end
  end

  logic       wr, wr_pulse, rd, inta;
  logic [7:0] req, ack_bit, w1c, ack_clr;
  logic [7:0] pend_d, insvc_d, eoi_clr;
  logic [2:0] w, h;
  logic       elig, ack_done, eoi, drive_vec;
  logic [7:0] rdata;

  assign wr       = ~nCSxINTC & ~nCPUxWR;
  assign wr_pulse = wr & ~wr_q;
  assign rd       = ~nCSxINTC & ~nCPUxRD;
  assign inta     = ~nCPUxM1 & ~nCPUxIORQ;

  assign req  = pend_q & mask_q;
  assign w    = msb_index(req);
  assign h    = msb_index(insvc_q);
  assign elig = (req != 8'h00) &&
                ((insvc_q == 8'h00) || (w > h));

  assign IEO = IEI & (insvc_q == 8'h00) & ~elig;

  assign ack_done = (state_q == ST_ACK) & ~inta;
  assign ack_bit  = 8'b1 << ackch_q;

  assign w1c = (wr_pulse && CPU_ADDR == INTC_PEND)
             ? (CPU_DIN & mode_q) : 8'h00;
  assign ack_clr = (ack_done && mode_q[ackch_q])
                 ? ack_bit : 8'h00;

  // New edge wins over any clear in the same cycle.
  assign pend_d = VALID &
    ((mode_q & (rise_v | (pend_q & ~(w1c | ack_clr)))) |
     (~mode_q & s_v));

  assign eoi = wr_pulse && (CPU_ADDR == INTC_INSVC) &&
               (insvc_q != 8'h00);
  assign eoi_clr = eoi ? (8'b1 << h) : 8'h00;
  assign insvc_d = VALID &
    ((insvc_q & ~eoi_clr) | (ack_done ? ack_bit : 8'h00));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q  <= RESET_MASK & VALID;
      mode_q  <= 8'h00;
      pend_q  <= 8'h00;
      insvc_q <= 8'h00;
      vbase_q <= 4'h0;
      ackch_q <= 3'd0;
      vec_q   <= 8'h00;
      wr_q    <= 1'b0;
      nint_q  <= 1'b1;
      state_q <= ST_IDLE;
    end else begin
      wr_q    <= wr;
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      nint_q  <= ~(elig & IEI);
      if (wr_pulse) begin
        unique case (1'b1)
          CPU_ADDR == INTC_MASK:  mask_q  <= CPU_DIN & VALID;
          CPU_ADDR == INTC_MODE:  mode_q  <= CPU_DIN & VALID;
          CPU_ADDR == INTC_VBASE: vbase_q <= CPU_DIN[7:4];
          default: ;
        endcase
      end
      unique case (state_q)
        ST_IDLE:
          if (inta) begin
            if (elig && IEI) begin
              ackch_q <= w;
              vec_q   <= {vbase_q, w, 1'b0};
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_SKIP;
            end
          end
        ST_ACK:  if (!inta) state_q <= ST_IDLE;
        ST_SKIP: if (!inta) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      CPU_ADDR == INTC_MASK:  rdata = mask_q;
      CPU_ADDR == INTC_MODE:  rdata = mode_q;
      CPU_ADDR == INTC_PEND:  rdata = pend_q;
      CPU_ADDR == INTC_VBASE: rdata = {vbase_q, 4'h0};
      CPU_ADDR == INTC_INSVC: rdata = insvc_q;
      default:                rdata = 8'h00;
    endcase
  end

  assign drive_vec = (state_q == ST_ACK) & inta;
  assign nDOUTxEN  = ~(drive_vec | rd);
  assign DOUT      = drive_vec ? vec_q :
                     rd        ? rdata : 8'h00;
  assign nINT      = nint_q;

endmodule

// File: tb/tb_z80_im2_intc.sv
// Self-checking bench for z80_im2_intc: directed scenarios
// plus randomized pend/mask/ack sequences against a priority model.
module tb_z80_im2_intc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = 8'h00;
  logic [2:0] irq3 = 3'b000;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic       ncs = 1'b1, ncs3 = 1'b1;
  logic       nrd = 1'b1, nwr = 1'b1;
  logic       nm1 = 1'b1, niorq = 1'b1;
  logic       iei = 1'b1;
  logic [7:0] dout, dout3;
  logic       nen, nen3, nint, nint3, ieo, ieo3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  z80_im2_intc u_dut (
    .CLK(clk), .RESET(rst), .IRQ(irq),
    .CPU_ADDR(addr), .CPU_DIN(din),
    .nCSxINTC(ncs), .nCPUxRD(nrd), .nCPUxWR(nwr),
    .nCPUxM1(nm1), .nCPUxIORQ(niorq), .IEI(iei),
    .DOUT(dout), .nDOUTxEN(nen), .nINT(nint), .IEO(ieo)
  );

  z80_im2_intc #(.NUM_IRQ(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .IRQ(irq3),
    .CPU_ADDR(addr), .CPU_DIN(din),
    .nCSxINTC(ncs3), .nCPUxRD(nrd), .nCPUxWR(nwr),
    .nCPUxM1(1'b1), .nCPUxIORQ(1'b1), .IEI(1'b1),
    .DOUT(dout3), .nDOUTxEN(nen3), .nINT(nint3), .IEO(ieo3)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d,
                        input bit sel3 = 0);
    @(negedge clk);
    addr = a; din = d; nwr = 1'b0;
    if (sel3) ncs3 = 1'b0; else ncs = 1'b0;
    @(negedge clk);
    nwr = 1'b1; ncs = 1'b1; ncs3 = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d,
                        input bit sel3 = 0);
    @(negedge clk);
    addr = a; nrd = 1'b0;
    if (sel3) ncs3 = 1'b0; else ncs = 1'b0;
    #1;
    d = sel3 ? dout3 : dout;
    nrd = 1'b1; ncs = 1'b1; ncs3 = 1'b1;
  endtask

  task automatic do_inta(output logic [7:0] v, output logic en_n);
    @(negedge clk);
    nm1 = 1'b0; niorq = 1'b0;
    @(negedge clk);
    v = dout; en_n = nen;
    nm1 = 1'b1; niorq = 1'b1;
    wait_clk(2);
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    @(negedge clk);
    irq = irq | bits;
    @(negedge clk);
    irq = irq & ~bits;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    if (nint !== 1'b1) begin n_fail++;
      $display("FAIL rst_nint got %b exp 1", nint); end
    n_checks++;
    if (nen !== 1'b1 || dout !== 8'h00) begin n_fail++;
      $display("FAIL rst_bus got en=%b d=%h exp 1/00", nen, dout); end
    n_checks++;
    if (ieo !== 1'b1) begin n_fail++;
      $display("FAIL rst_ieo got %b exp 1", ieo); end
    n_checks++;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), r);
      if (r !== 8'h00) begin n_fail++;
        $display("FAIL rst_reg%0d got %h exp 00", a, r); end
      n_checks++;
    end
  endtask

  task automatic test_basic_ack();
    logic [7:0] v, r;
    logic en;
    wr_reg(3'd0, 8'hFF);
    wr_reg(3'd1, 8'hFF);
    wr_reg(3'd3, 8'hA5);
    rd_reg(3'd3, r);
    if (r !== 8'hA0) begin n_fail++;
      $display("FAIL vbase_rd got %h exp a0", r); end
    n_checks++;
    irq[5] = 1'b1;
    wait_clk(3);
    if (nint !== 1'b1) begin n_fail++;
      $display("FAIL lat_edge3 got %b exp 1", nint); end
    n_checks++;
    wait_clk(1);
    if (nint !== 1'b0) begin n_fail++;
      $display("FAIL lat_edge4 got %b exp 0", nint); end
    n_checks++;
    irq[5] = 1'b0;
    do_inta(v, en);
    if (v !== 8'hAA || en !== 1'b0) begin n_fail++;
      $display("FAIL t1_vec got %h/%b exp aa/0", v, en); end
    n_checks++;
    rd_reg(3'd4, r);
    if (r !== 8'h20) begin n_fail++;
      $display("FAIL t1_insvc got %h exp 20", r); end
    n_checks++;
    rd_reg(3'd2, r);
    if (r !== 8'h00 || nint !== 1'b1) begin n_fail++;
      $display("FAIL t1_pend got %h/%b exp 00/1", r, nint); end
    n_checks++;
  endtask

  task automatic test_nesting();
    logic [7:0] v, r;
    logic en;
    pulse_irq(8'h04);
    wait_clk(5);
    rd_reg(3'd2, r);
    if (nint !== 1'b1 || r !== 8'h04) begin n_fail++;
      $display("FAIL t2_low got nint=%b pend=%h exp 1/04", nint, r); end
    n_checks++;
    pulse_irq(8'h80);
    wait_clk(5);
    if (nint !== 1'b0) begin n_fail++;
      $display("FAIL t2_hi_req got %b exp 0", nint); end
    n_checks++;
    do_inta(v, en);
    if (v !== 8'hAE) begin n_fail++;
      $display("FAIL t2_vec got %h exp ae", v); end
    n_checks++;
    rd_reg(3'd4, r);
    if (r !== 8'hA0) begin n_fail++;
      $display("FAIL t2_insvc got %h exp a0", r); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
    rd_reg(3'd4, r);
    wait_clk(2);
    if (r !== 8'h20 || nint !== 1'b1) begin n_fail++;
      $display("FAIL t2_eoi1 got %h/%b exp 20/1", r, nint); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
    rd_reg(3'd4, r);
    wait_clk(2);
    if (r !== 8'h00 || nint !== 1'b0) begin n_fail++;
      $display("FAIL t2_eoi2 got %h/%b exp 00/0", r, nint); end
    n_checks++;
    do_inta(v, en);
    if (v !== 8'hA4) begin n_fail++;
      $display("FAIL t2_vec2 got %h exp a4", v); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
  endtask

  task automatic test_level();
    logic [7:0] v, r;
    logic en;
    wr_reg(3'd1, 8'h00);
    wr_reg(3'd0, 8'h01);
    irq[0] = 1'b1;
    wait_clk(5);
    if (nint !== 1'b0) begin n_fail++;
      $display("FAIL t3_req got %b exp 0", nint); end
    n_checks++;
    do_inta(v, en);
    if (v !== 8'hA0) begin n_fail++;
      $display("FAIL t3_vec got %h exp a0", v); end
    n_checks++;
    wait_clk(2);
    rd_reg(3'd2, r);
    if (nint !== 1'b1 || r !== 8'h01) begin n_fail++;
      $display("FAIL t3_insvc_hold got %b/%h exp 1/01", nint, r); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
    wait_clk(2);
    if (nint !== 1'b0) begin n_fail++;
      $display("FAIL t3_rereq got %b exp 0", nint); end
    n_checks++;
    irq[0] = 1'b0;
    wait_clk(5);
    rd_reg(3'd2, r);
    if (nint !== 1'b1 || r !== 8'h00) begin n_fail++;
      $display("FAIL t3_drop got %b/%h exp 1/00", nint, r); end
    n_checks++;
  endtask

  task automatic test_daisy();
    logic [7:0] v, r;
    logic en;
    wr_reg(3'd1, 8'hFF);
    wr_reg(3'd0, 8'hFF);
    iei = 1'b0;
    pulse_irq(8'h08);
    wait_clk(5);
    if (nint !== 1'b1 || ieo !== 1'b0) begin n_fail++;
      $display("FAIL t4_iei0 got nint=%b ieo=%b exp 1/0", nint, ieo); end
    n_checks++;
    do_inta(v, en);
    rd_reg(3'd4, r);
    if (en !== 1'b1 || r !== 8'h00) begin n_fail++;
      $display("FAIL t4_skip got en=%b insvc=%h exp 1/00", en, r); end
    n_checks++;
    iei = 1'b1;
    wait_clk(2);
    if (nint !== 1'b0 || ieo !== 1'b0) begin n_fail++;
      $display("FAIL t4_iei1 got nint=%b ieo=%b exp 0/0", nint, ieo); end
    n_checks++;
    do_inta(v, en);
    if (v !== 8'hA6) begin n_fail++;
      $display("FAIL t4_vec got %h exp a6", v); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
    wait_clk(2);
    if (ieo !== 1'b1) begin n_fail++;
      $display("FAIL t4_idle_ieo got %b exp 1", ieo); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, r;
    logic en;
    pulse_irq(8'h02);
    wait_clk(5);
    do_inta(v, en);
    if (v !== 8'hA2) begin n_fail++;
      $display("FAIL t5_vec1 got %h exp a2", v); end
    n_checks++;
    // rise reaches PEND on the same edge that captures the W1C
    @(negedge clk);
    irq[6] = 1'b1;
    wait_clk(2);
    addr = 3'd2; din = 8'h40; ncs = 1'b0; nwr = 1'b0;
    @(negedge clk);
    ncs = 1'b1; nwr = 1'b1; irq[6] = 1'b0;
    rd_reg(3'd2, r);
    if (r !== 8'h40) begin n_fail++;
      $display("FAIL t5_set_wins got %h exp 40", r); end
    n_checks++;
    wr_reg(3'd2, 8'h40);
    rd_reg(3'd2, r);
    if (r !== 8'h00) begin n_fail++;
      $display("FAIL t5_w1c got %h exp 00", r); end
    n_checks++;
    pulse_irq(8'h40);
    wait_clk(5);
    do_inta(v, en);
    rd_reg(3'd4, r);
    if (v !== 8'hAC || r !== 8'h42) begin n_fail++;
      $display("FAIL t5_nest got %h/%h exp ac/42", v, r); end
    n_checks++;
    @(negedge clk);
    addr = 3'd4; ncs = 1'b0; nwr = 1'b0;
    wait_clk(5);
    ncs = 1'b1; nwr = 1'b1;
    rd_reg(3'd4, r);
    if (r !== 8'h02) begin n_fail++;
      $display("FAIL t5_held_eoi got %h exp 02", r); end
    n_checks++;
    wr_reg(3'd4, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] m, p, vb, rem, v, r;
    logic [2:0] ch;
    logic en;
    int guard;
    for (int it = 0; it < 6; it++) begin
      m  = 8'($urandom_range(1, 255));
      p  = 8'($urandom_range(1, 255));
      vb = 8'($urandom) & 8'hF0;
      wr_reg(3'd0, m);
      wr_reg(3'd3, vb);
      rd_reg(3'd0, r);
      if (r !== m) begin n_fail++;
        $display("FAIL rnd_mask got %h exp %h", r, m); end
      n_checks++;
      pulse_irq(p);
      wait_clk(5);
      rd_reg(3'd2, r);
      if (r !== p) begin n_fail++;
        $display("FAIL rnd_pend got %h exp %h", r, p); end
      n_checks++;
      rem = p & m;
      guard = 0;
      while (rem != 8'h00 && guard < 8) begin
        guard++;
        ch = 3'd0;
        for (int b = 0; b < 8; b++) if (rem[b]) ch = 3'(b);
        if (nint !== 1'b0) begin n_fail++;
          $display("FAIL rnd_req got %b exp 0 ch %0d", nint, ch); end
        n_checks++;
        do_inta(v, en);
        if (v !== (vb | {4'h0, ch, 1'b0}) || en !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_vec got %h exp %h", v,
                   vb | {4'h0, ch, 1'b0});
        end
        n_checks++;
        rd_reg(3'd4, r);
        if (r !== (8'h01 << ch)) begin n_fail++;
          $display("FAIL rnd_insvc got %h exp %h", r, 8'h01 << ch); end
        n_checks++;
        rem[ch] = 1'b0;
        wr_reg(3'd4, 8'h00);
        wait_clk(1);
      end
      wait_clk(2);
      rd_reg(3'd2, r);
      if (nint !== 1'b1 || r !== (p & ~m)) begin n_fail++;
        $display("FAIL rnd_left got %b/%h exp 1/%h", nint, r, p & ~m); end
      n_checks++;
      wr_reg(3'd2, 8'hFF);
    end
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] r;
    wr_reg(3'd0, 8'hFF);
    pulse_irq(8'h10);
    wait_clk(5);
    @(negedge clk);
    nm1 = 1'b0; niorq = 1'b0;
    @(negedge clk);
    if (nen !== 1'b0) begin n_fail++;
      $display("FAIL t6_in_ack got %b exp 0", nen); end
    n_checks++;
    rst = 1'b1;
    #1;
    if (nen !== 1'b1 || nint !== 1'b1) begin n_fail++;
      $display("FAIL t6_async got en=%b nint=%b exp 1/1", nen, nint); end
    n_checks++;
    nm1 = 1'b1; niorq = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd_reg(3'(a), r);
      if (r !== 8'h00) begin n_fail++;
        $display("FAIL t6_reg%0d got %h exp 00", a, r); end
      n_checks++;
    end
    wr_reg(3'd0, 8'hFF, 1'b1);
    rd_reg(3'd0, r, 1'b1);
    if (r !== 8'h07) begin n_fail++;
      $display("FAIL t6_n3_mask got %h exp 07", r); end
    n_checks++;
  endtask

  initial begin
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    test_reset();
    test_basic_ack();
    test_nesting();
    test_level();
    test_daisy();
    test_back_to_back();
    test_random();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
